// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle 9-bit-instruction core control path.
//   seq_state_t : sequencer state encoding
//   CTL_*       : bit positions inside the decoder control word
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    localparam int CTL_BR     = 9;  // branch instruction
    localparam int CTL_BRT    = 8;  // branch type: 0 absolute, 1 relative
    localparam int CTL_WEN    = 7;  // register-file write
    localparam int CTL_COUTW  = 6;  // carry-register write
    localparam int CTL_HALT   = 4;  // halt
    localparam int CTL_MRD    = 3;  // data-memory read
    localparam int CTL_MWR    = 2;  // data-memory write
    localparam int CTL_SEL_LO = 0;  // low bit of the 2-bit writeback select

endpackage

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
// Program counter register with its next-PC selection.
//   clk, reset   : clock, synchronous active-high reset (PC -> 0)
//   clear        : restart request, PC -> 0
//   update       : load the next PC (asserted during writeback)
//   br_taken     : branch instruction whose condition is true
//   br_rel       : taken branch is PC-relative (else absolute)
//   br_target    : absolute target or signed relative offset
//   pc           : current PC / instruction ROM address
// ----------------------------------------------------------------------------
module pc_unit #(
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          update,
    input  logic          br_taken,
    input  logic          br_rel,
    input  logic [IW-1:0] br_target,
    output logic [IW-1:0] pc
);

    logic signed [IW-1:0] br_off;
    logic        [IW-1:0] pc_next;

    assign br_off = signed'(br_target);

    // Two's-complement addition in IW bits gives pc + offset modulo 2^IW,
    // so negative offsets and wrap-around need no special handling.
    always_comb begin
        pc_next = pc + IW'(1);
        if (br_taken) begin
            if (br_rel) begin
                pc_next = IW'(signed'(pc) + br_off);
            end else begin
                pc_next = br_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc <= '0;
        end else if (update) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// ----------------------------------------------------------------------------
// mc_sequencer
// Multi-cycle control sequencer: steps each instruction through
// FETCH / DECODE / EXEC / [MEM] / WB, owns the PC, handles the data-memory
// req/ack handshake with timeout, and counts retired instructions.
//   clk, reset    : clock, synchronous active-high reset
//   start         : begin / restart (honoured in IDLE and HALT only)
//   ctl_i         : decoder control word for the instruction in the IR
//   br_flag_i     : ALU branch condition (used in WB)
//   br_target_i   : branch target / offset (used in WB)
//   mem_ack_i     : data-memory access complete (used in MEM)
//   pc_o          : instruction ROM address
//   ir_we_o       : IR load strobe (FETCH)
//   alu_we_o      : ALU result/carry capture strobe (EXEC)
//   rf_we_o       : register-file write enable (WB)
//   cout_we_o     : carry-register write enable (WB)
//   rf_sel_o      : writeback source select
//   mem_req_o     : data-memory request (MEM)
//   mem_we_o      : request is a write
//   done          : core halted
//   err_o         : halted by a memory timeout
//   retired_o     : saturating retired-instruction count
// ----------------------------------------------------------------------------
module mc_sequencer
    import cpu_pkg::*;
#(
    parameter int IW          = 8,
    parameter int CW          = 10,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    ctl_i,
    input  logic             br_flag_i,
    input  logic [IW-1:0]    br_target_i,
    input  logic             mem_ack_i,
    output logic [IW-1:0]    pc_o,
    output logic             ir_we_o,
    output logic             alu_we_o,
    output logic             rf_we_o,
    output logic             cout_we_o,
    output logic [1:0]       rf_sel_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             done,
    output logic             err_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    seq_state_t        state, state_next;
    logic [CW-1:0]     ctl_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retired_q;
    logic              err_q;
    logic              mem_timeout;
    logic              restart;
    logic              retire;

    // Control-word bits with no role in sequencing (reserved bit and any
    // bits above the branch flag) are kept only so the whole word is consumed.
    logic unused_ctl;
    assign unused_ctl = ^{ctl_q[5], ctl_q[CW-1:CTL_BR]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign restart     = (state == S_HALT) && start;
    // A halt retires in DECODE because it never reaches WB.
    assign retire      = (state == S_WB) || ((state == S_DECODE) && ctl_i[CTL_HALT]);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = ctl_i[CTL_HALT] ? S_HALT : S_EXEC;
            S_EXEC:   state_next = (ctl_q[CTL_MRD] || ctl_q[CTL_MWR]) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ack_i) begin
                    state_next = S_WB;
                end else if (mem_timeout) begin
                    state_next = S_HALT;
                end
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   if (start) state_next = S_FETCH;
            default:  state_next = S_IDLE;
        endcase
    end

    // ---- control registers: control word, wait counter, retire count, error ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q     <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                ctl_q <= ctl_i;
            end

            // Held at zero outside MEM, so every MEM visit starts counting from 0.
            wait_cnt <= (state == S_MEM) ? wait_cnt + WAIT_W'(1) : '0;

            if (restart) begin
                retired_q <= '0;
            end else if (retire) begin
                retired_q <= sat_inc(retired_q);
            end

            if (restart) begin
                err_q <= 1'b0;
            end else if ((state == S_MEM) && !mem_ack_i && mem_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    pc_unit #(
        .IW(IW)
    ) u_pc_unit (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .update   (state == S_WB),
        .br_taken (ctl_q[CTL_BR] && br_flag_i),
        .br_rel   (ctl_q[CTL_BRT]),
        .br_target(br_target_i),
        .pc       (pc_o)
    );

    // ---- output decode (Moore: state register and ctl_q only) ----
    always_comb begin
        ir_we_o   = 1'b0;
        alu_we_o  = 1'b0;
        rf_we_o   = 1'b0;
        cout_we_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        done      = 1'b0;
        case (state)
            S_FETCH: ir_we_o = 1'b1;
            S_EXEC:  alu_we_o = 1'b1;
            S_MEM: begin
                mem_req_o = 1'b1;
                // Write wins when both read and write are set.
                mem_we_o  = ctl_q[CTL_MWR];
            end
            S_WB: begin
                rf_we_o   = ctl_q[CTL_WEN];
                cout_we_o = ctl_q[CTL_COUTW];
            end
            S_HALT:  done = 1'b1;
            default: ;
        endcase
    end

    assign rf_sel_o  = ctl_q[CTL_SEL_LO +: 2];
    assign err_o     = err_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mc_sequencer
// Directed bench for mc_sequencer: straight-line instruction sequences with
// hand-computed expected PC, strobe and counter values.
// ----------------------------------------------------------------------------
module tb_mc_sequencer;

    localparam int IW          = 8;
    localparam int CW          = 10;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CW-1:0]    ctl_i;
    logic             br_flag_i;
    logic [IW-1:0]    br_target_i;
    logic             mem_ack_i;
    logic [IW-1:0]    pc_o;
    logic             ir_we_o;
    logic             alu_we_o;
    logic             rf_we_o;
    logic             cout_we_o;
    logic [1:0]       rf_sel_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             done;
    logic             err_o;
    logic [CNT_W-1:0] retired_o;

    int errors = 0;
    int checks = 0;
    int rf_we_cnt = 0;

    mc_sequencer #(
        .IW         (IW),
        .CW         (CW),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ctl_i      (ctl_i),
        .br_flag_i  (br_flag_i),
        .br_target_i(br_target_i),
        .mem_ack_i  (mem_ack_i),
        .pc_o       (pc_o),
        .ir_we_o    (ir_we_o),
        .alu_we_o   (alu_we_o),
        .rf_we_o    (rf_we_o),
        .cout_we_o  (cout_we_o),
        .rf_sel_o   (rf_sel_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .done       (done),
        .err_o      (err_o),
        .retired_o  (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file write pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rf_we_o === 1'b1) rf_we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one non-memory instruction starting in FETCH; ends in the next FETCH.
    task automatic run_nonmem(input logic [CW-1:0] ctl, input logic flag,
                              input logic [IW-1:0] target);
        ctl_i       = ctl;
        br_flag_i   = flag;
        br_target_i = target;
        repeat (4) step();
        br_flag_i   = 1'b0;
    endtask

    int base;
    int hold;

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        ctl_i       = '0;
        br_flag_i   = 1'b0;
        br_target_i = '0;
        mem_ack_i   = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_pc",      32'(pc_o),      32'h0);
        check("rst_done",    32'(done),      32'h0);
        check("rst_err",     32'(err_o),     32'h0);
        check("rst_retired", 32'(retired_o), 32'h0);
        check("rst_memreq",  32'(mem_req_o), 32'h0);
        step();
        check("idle_no_fetch", 32'(ir_we_o), 32'h0);

        // Start, then three ALU instructions writing reg + carry, rf_sel=1
        start = 1'b1;
        step();
        start = 1'b0;
        base  = rf_we_cnt;
        for (int i = 0; i < 3; i++) begin
            ctl_i = 10'h0C1;
            check("seq_fetch_ir", 32'(ir_we_o), 32'h1);
            check("seq_fetch_pc", 32'(pc_o), 32'(i));
            step();
            step();
            check("seq_exec_alu", 32'(alu_we_o), 32'h1);
            step();
            check("seq_wb_rfwe",  32'(rf_we_o),   32'h1);
            check("seq_wb_coutwe", 32'(cout_we_o), 32'h1);
            check("seq_wb_rfsel", 32'(rf_sel_o),  32'h1);
            step();
        end
        check("seq_pc3",      32'(pc_o),      32'h3);
        check("seq_retired3", 32'(retired_o), 32'h3);
        check("seq_rfwe_cnt", 32'(rf_we_cnt - base), 32'h3);

        // Load, ack on the 3rd MEM cycle: 7 cycles FETCH to FETCH
        ctl_i = 10'h088;
        check("ld_fetch_ir", 32'(ir_we_o), 32'h1);
        step();
        step();
        step();
        check("ld_m1_req", 32'(mem_req_o), 32'h1);
        check("ld_m1_we",  32'(mem_we_o),  32'h0);
        step();
        check("ld_m2_req", 32'(mem_req_o), 32'h1);
        step();
        check("ld_m3_req", 32'(mem_req_o), 32'h1);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check("ld_wb_rfwe",  32'(rf_we_o),   32'h1);
        check("ld_wb_noreq", 32'(mem_req_o), 32'h0);
        check("ld_wb_pc",    32'(pc_o),      32'h3);
        step();
        check("ld_pc",      32'(pc_o),      32'h4);
        check("ld_fetch2",  32'(ir_we_o),   32'h1);
        check("ld_retired", 32'(retired_o), 32'h4);

        // Branches
        run_nonmem(10'h200, 1'b1, 8'h10);
        check("br_abs_10", 32'(pc_o), 32'h10);
        run_nonmem(10'h300, 1'b1, 8'hFE);
        check("br_rel_m2", 32'(pc_o), 32'h0E);
        run_nonmem(10'h200, 1'b1, 8'hFF);
        check("br_abs_ff", 32'(pc_o), 32'hFF);
        run_nonmem(10'h200, 1'b0, 8'h33);
        check("br_nt_wrap", 32'(pc_o), 32'h00);
        run_nonmem(10'h200, 1'b1, 8'h40);
        check("br_abs_40", 32'(pc_o), 32'h40);
        run_nonmem(10'h200, 1'b1, 8'h05);
        check("br_abs_05",  32'(pc_o),      32'h05);
        check("br_retired", 32'(retired_o), 32'd10);

        // Halt at pc=5 with start held through FETCH and DECODE
        ctl_i = 10'h010;
        start = 1'b1;
        check("halt_fetch_pc", 32'(pc_o), 32'h5);
        step();
        check("halt_decode_done", 32'(done), 32'h0);
        step();
        start = 1'b0;
        check("halt_done",    32'(done),      32'h1);
        check("halt_err",     32'(err_o),     32'h0);
        check("halt_retired", 32'(retired_o), 32'd11);
        check("halt_pc",      32'(pc_o),      32'h5);
        step();
        step();
        check("halt_stays",    32'(done), 32'h1);
        check("halt_pc_stays", 32'(pc_o), 32'h5);

        // Restart from HALT
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_done",    32'(done),      32'h0);
        check("rs_pc",      32'(pc_o),      32'h0);
        check("rs_retired", 32'(retired_o), 32'h0);
        check("rs_fetch",   32'(ir_we_o),   32'h1);

        // Store with no ack: timeout
        run_nonmem(10'h0C1, 1'b0, 8'h00);
        check("st_pre_retired", 32'(retired_o), 32'h1);
        ctl_i = 10'h004;
        step();
        step();
        step();
        hold = 0;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            if (mem_req_o === 1'b1 && mem_we_o === 1'b1 && done === 1'b0) hold++;
            step();
        end
        check("to_req_cycles", 32'(hold),      32'(MEM_TIMEOUT));
        check("to_req_drop",   32'(mem_req_o), 32'h0);
        check("to_done",       32'(done),      32'h1);
        check("to_err",        32'(err_o),     32'h1);
        check("to_retired",    32'(retired_o), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_rs_done",    32'(done),      32'h0);
        check("to_rs_err",     32'(err_o),     32'h0);
        check("to_rs_pc",      32'(pc_o),      32'h0);
        check("to_rs_retired", 32'(retired_o), 32'h0);

        // Reset in the 2nd MEM cycle, with ack present
        run_nonmem(10'h0C1, 1'b0, 8'h00);
        check("rm_pre_pc", 32'(pc_o), 32'h1);
        ctl_i = 10'h008;
        step();
        step();
        step();
        step();
        check("rm_m2_req", 32'(mem_req_o), 32'h1);
        reset     = 1'b1;
        mem_ack_i = 1'b1;
        step();
        reset     = 1'b0;
        mem_ack_i = 1'b0;
        check("rm_req_drop", 32'(mem_req_o), 32'h0);
        check("rm_pc",       32'(pc_o),      32'h0);
        check("rm_retired",  32'(retired_o), 32'h0);
        check("rm_idle",     32'(ir_we_o),   32'h0);
        check("rm_done",     32'(done),      32'h0);
        step();
        step();
        check("rm_idle_hold", 32'(ir_we_o),   32'h0);
        check("rm_no_wb",     32'(retired_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Parametrised multi-cycle control sequencer for the 9-bit-instruction core, the successor to the single-cycle top-level control. It owns the program counter and steps each instruction through FETCH/DECODE/EXEC/MEM/WB states. It drives the instruction-register, ALU-capture, register-file and data-memory strobes from the decoder's control word. It adds what the single-cycle core lacks: a start/restart handshake, a data-memory req/ack handshake with timeout, relative or absolute branches, and a retired-instruction counter.

## Interface
- `IW`, 8: PC width; instruction ROM depth is 2^IW.
- `CW`, 10: decoder control-word width; must be ≥ 10.
- `MEM_TIMEOUT`, 15: maximum cycles spent in MEM waiting for ack; must be ≥ 1.
- `CNT_W`, 16: retired-instruction counter width.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin or restart execution; sampled only in IDLE or HALT.
- `ctl_i` in CW: decoder control word for the instruction currently in the IR.
- `br_flag_i` in 1: ALU branch condition; sampled in WB.
- `br_target_i` in IW: branch LUT output; sampled in WB.
- `mem_ack_i` in 1: data memory has completed the access.
- `pc_o` out IW: instruction ROM address.
- `ir_we_o` out 1: latch the ROM output into the IR.
- `alu_we_o` out 1: capture the ALU result and carry.
- `rf_we_o` out 1: register-file write enable.
- `cout_we_o` out 1: carry-register write enable.
- `rf_sel_o` out 2: register writeback source select.
- `mem_req_o` out 1: data-memory request.
- `mem_we_o` out 1: request is a write (1) or a read (0).
- `done` out 1: core halted.
- `err_o` out 1: halted because of a memory timeout.
- `retired_o` out CNT_W: count of retired instructions.

## Operation
- Control-word fields (bit indices of `ctl_i`):
  - 9 = branch
  - 8 = branch type (0 absolute, 1 relative)
  - 7 = reg write
  - 6 = carry write
  - 5 = reserved, ignored
  - 4 = halt
  - 3 = mem read
  - 2 = mem write
  - 1:0 = rf_sel
  - bits above 9 are ignored.
- `ctl_i` is registered into `ctl_q` in DECODE; all later strobes use `ctl_q`.
- States and transitions:
  - IDLE: waits for `start`, then FETCH.
  - FETCH: `ir_we_o`=1; next state DECODE.
  - DECODE: capture `ctl_q`. If the halt bit is set, go to HALT and increment `retired_o`; otherwise go to EXEC.
  - EXEC: `alu_we_o`=1. Go to MEM if mem read or mem write is set, else to WB.
  - MEM: `mem_req_o`=1 and `mem_we_o`=`ctl_q[2]`.
    - `mem_ack_i`=1 → WB.
    - Else, wait counter == MEM_TIMEOUT-1 → HALT with `err_o`=1.
    - Else, increment the wait counter. The counter clears on entry to MEM.
  - WB: `rf_we_o`=`ctl_q[7]`, `cout_we_o`=`ctl_q[6]`; update PC; increment `retired_o`; next state FETCH.
  - HALT: `done`=1. On `start`, clear `done`, `err_o`, `retired_o` and PC to 0, then go to FETCH.
- Next PC in WB:
  - Branch not taken (`ctl_q[9]`=0 or `br_flag_i`=0): pc+1.
  - Taken, absolute: `br_target_i`.
  - Taken, relative: pc + `br_target_i` as a signed two's-complement IW-bit value.
  - All PC arithmetic is modulo 2^IW, so PC wraps from 2^IW−1 to 0 silently.
- `retired_o` saturates at all-ones; it does not wrap.
- `rf_sel_o` = `ctl_q[1:0]` in every state.
- If both mem read and mem write are set, the access is a write.
- `mem_ack_i` outside MEM is ignored. `start` in FETCH through WB is ignored.
- `reset` at any point, including mid-MEM, returns the block to the reset state on the next edge. `mem_req_o` drops that same edge.

## Timing
- Reset values:
  - state IDLE, PC 0, `ctl_q` 0, wait counter 0, `retired_o` 0.
  - `done` 0, `err_o` 0, all strobes 0.
- Strobes are Moore outputs decoded from the state register and `ctl_q`. No input reaches any output combinationally.
- Instruction latency:
  - Non-memory instruction: 4 cycles.
  - Memory instruction: 4 + N cycles, where N is the number of MEM cycles including the ack cycle (N ≥ 1).
  - Halt instruction: 2 cycles to `done`=1.
- Timeout: `mem_req_o` is held exactly MEM_TIMEOUT cycles. `done` and `err_o` rise on the following edge.
- `pc_o` changes only on the WB→FETCH edge, on restart, or on reset. It is stable for the whole FETCH cycle.

## Structure
- Package `cpu_pkg`:
  - state enum `seq_state_t`.
  - localparams for the control-bit indices: `CTL_BR`, `CTL_BRT`, `CTL_WEN`, `CTL_COUTW`, `CTL_HALT`, `CTL_MRD`, `CTL_MWR`, `CTL_SEL_LO`.
- Sub-module `pc_unit`: PC register plus next-PC mux and adder (increment / absolute / relative), parametrised by IW.
- Everything else (FSM, wait counter, retired counter) lives in `mc_sequencer`.

## Test plan
- Reset, then `start` pulse, then 3 non-memory non-branch instructions: `pc_o` steps 0→1→2→3 every 4 cycles; `retired_o`=3; `rf_we_o` pulses exactly 3 times, each in WB.
- Load with ack on the 3rd MEM cycle: `mem_req_o` high 3 cycles with `mem_we_o`=0; instruction takes 7 cycles; PC advances by 1.
- Store with no ack, MEM_TIMEOUT=15: `mem_req_o` high 15 cycles, then `done`=1 and `err_o`=1. A following `start` clears both, sets `pc_o`=0 and `retired_o`=0.
- At pc=0x10, taken relative branch with `br_target_i`=0xFE: next `pc_o`=0x0E. At pc=0xFF, not-taken branch: next `pc_o`=0x00. Taken absolute branch with target 0x40: next `pc_o`=0x40.
- Halt instruction at pc=5: `done`=1 two cycles after FETCH; `retired_o` increments by 1; `pc_o` stays 5; `start` held during FETCH–WB has no effect.
- `reset` asserted in the 2nd MEM cycle: next edge gives `mem_req_o`=0, state IDLE, `pc_o`=0, `retired_o`=0; `mem_ack_i` in that cycle is ignored.
